// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one outstanding instruction fetch at a time and
// loads the IF/ID register, discarding responses made stale by a branch redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ID_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PC
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DROP  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        load_mem;
    logic        load_hold;

    assign imem_req  = (state == FETCH) & ~reset;
    assign imem_addr = pc;

    // A redirect or a stall always beats a load into IF/ID
    assign load_mem  = (state == WAIT) & imem_rvalid & ~redirect & ~ID_stall;
    assign load_hold = (state == HOLD) & ~redirect & ~ID_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= 32'h0;
            hold_pc     <= 32'h0;
            IF_ID_valid <= 1'b0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_PC    <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect)
                        pc <= redirect_pc;
                    // A request accepted in the redirect cycle already targets the old path
                    if (imem_ready)
                        state <= redirect ? DROP : WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else begin
                            pc <= pc + 32'd4;
                            if (ID_stall) begin
                                state      <= HOLD;
                                hold_instr <= imem_rdata;
                                hold_pc    <= pc;
                            end
                        end
                    end else if (redirect) begin
                        state <= DROP;
                        pc    <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        state <= FETCH;
                        pc    <= redirect_pc;
                    end else if (!ID_stall) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    if (imem_rvalid)
                        state <= FETCH;
                    if (redirect)
                        pc <= redirect_pc;
                end
            endcase

            if (redirect) begin
                IF_ID_valid <= 1'b0;
                IF_ID_instr <= NOP_INSTR;
            end else if (ID_stall) begin
                IF_ID_valid <= IF_ID_valid;
            end else if (load_mem) begin
                IF_ID_valid <= 1'b1;
                IF_ID_instr <= imem_rdata;
                IF_ID_PC    <= pc;
            end else if (load_hold) begin
                IF_ID_valid <= 1'b1;
                IF_ID_instr <= hold_instr;
                IF_ID_PC    <= hold_pc;
            end else begin
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with explicit expectations, then random
// traffic checked every cycle against a transaction-flag reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, redirect, ID_stall, imem_ready, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, IF_ID_valid;
    logic [31:0] imem_addr, IF_ID_instr, IF_ID_PC;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .ID_stall(ID_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_valid(IF_ID_valid), .IF_ID_instr(IF_ID_instr), .IF_ID_PC(IF_ID_PC)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pending response (m_out), whether it is stale, and a buffered one
    logic        m_out, m_stale, m_buf, m_v;
    logic [31:0] m_pc, m_bi, m_bp, m_instr, m_ifpc;

    task automatic model_step();
        logic fetching;
        fetching = !m_out && !m_buf;
        if (reset) begin
            m_out = 0; m_stale = 0; m_buf = 0; m_bi = 0; m_bp = 0;
            m_pc = RESET_PC; m_v = 0; m_instr = NOP; m_ifpc = 0;
        end else begin
            if (redirect) begin
                m_v = 0; m_instr = NOP;
            end else if (ID_stall) begin
                m_v = m_v;
            end else if (m_out && !m_stale && imem_rvalid) begin
                m_v = 1; m_instr = imem_rdata; m_ifpc = m_pc;
            end else if (m_buf) begin
                m_v = 1; m_instr = m_bi; m_ifpc = m_bp;
            end else begin
                m_v = 0;
            end

            if (fetching) begin
                if (imem_ready) begin m_out = 1; m_stale = redirect; end
                if (redirect) m_pc = redirect_pc;
            end else if (m_out && !m_stale) begin
                if (imem_rvalid) begin
                    m_out = 0;
                    if (redirect) m_pc = redirect_pc;
                    else begin
                        if (ID_stall) begin m_buf = 1; m_bi = imem_rdata; m_bp = m_pc; end
                        m_pc = m_pc + 4;
                    end
                end else if (redirect) begin
                    m_stale = 1; m_pc = redirect_pc;
                end
            end else if (m_buf) begin
                if (redirect) begin m_buf = 0; m_pc = redirect_pc; end
                else if (!ID_stall) m_buf = 0;
            end else begin
                if (imem_rvalid) begin m_out = 0; m_stale = 0; end
                if (redirect) m_pc = redirect_pc;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_req", {31'b0, imem_req}, {31'b0, !reset && !m_out && !m_buf});
        check("imem_addr", imem_addr, m_pc);
        check("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_v});
        check("IF_ID_instr", IF_ID_instr, m_instr);
        check("IF_ID_PC", IF_ID_PC, m_ifpc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic rdr, input logic [31:0] rpc, input logic stl);
        reset = rst; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        redirect = rdr; redirect_pc = rpc; ID_stall = stl;
    endtask

    logic [31:0] a_data [3];

    initial begin
        a_data[0] = 32'hA000_0000; a_data[1] = 32'hA111_1111; a_data[2] = 32'hA222_2222;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("rst_instr", IF_ID_instr, NOP);
        check("rst_req", {31'b0, imem_req}, 32'd0);

        // Streaming fetch: one instruction every second cycle
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            #1 check("stream_addr", imem_addr, 32'(4 * i));
            tick();
            check("stream_bubble", {31'b0, IF_ID_valid}, 32'd0);
            drive(0, 1, 1, a_data[i], 0, 0, 0);
            tick();
            check("stream_valid", {31'b0, IF_ID_valid}, 32'd1);
            check("stream_pc", IF_ID_PC, 32'(4 * i));
            check("stream_instr", IF_ID_instr, a_data[i]);
        end

        // Stall arriving with the response: buffered, then released
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'hB000_000C, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick(); tick();
        check("stall_keep_pc", IF_ID_PC, 32'd8);
        check("stall_no_req", {31'b0, imem_req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        check("stall_release_pc", IF_ID_PC, 32'd12);
        check("stall_release_instr", IF_ID_instr, 32'hB000_000C);
        check("stall_next_addr", imem_addr, 32'd16);

        // Redirect while waiting: stale response discarded
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 32'h100, 0); tick();
        check("redir_flush_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("redir_flush_instr", IF_ID_instr, NOP);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0); tick();
        check("redir_stale_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h100);

        // Redirect coincident with response under stall
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'hC0C0_C0C0, 1, 32'h200, 1); tick();
        check("rdr_stall_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("rdr_stall_req", {31'b0, imem_req}, 32'd1);
        check("rdr_stall_addr", imem_addr, 32'h200);

        // Memory not ready; redirect while request is pending
        for (int c = 1; c <= 5; c++) begin
            drive(0, 0, 0, 0, (c == 2), 32'h40, 0); tick();
            check("busy_req", {31'b0, imem_req}, 32'd1);
        end
        check("busy_addr", imem_addr, 32'h40);
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'h4040_4040, 0, 0, 0); tick();
        check("busy_fetch_pc", IF_ID_PC, 32'h40);

        // PC wrap
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'hFFFF_0000, 0, 0, 0); tick();
        check("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset while waiting; later stray response ignored
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        check("midrst_valid", {31'b0, IF_ID_valid}, 32'd0);
        drive(0, 0, 1, 32'h5555_5555, 0, 0, 0); tick();
        check("stray_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("stray_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 4), $urandom,
                  ($urandom_range(0, 9) == 0), rpc, ($urandom_range(0, 9) < 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
